// File: rtl/mem_arbiter2.sv
// Two-port round-robin arbiter sharing one RAM port between the core (port 0)
// and a loader/DMA/debug master (port 1), with optional lock for atomic bursts.
module mem_arbiter2 #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          mem_we_q, mem_we_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          grant_s;
  logic          win_s;
  logic          own_req_s;
  logic          own_lock_s;

  assign own_req_s  = owner_q ? req1 : req0;
  assign own_lock_s = owner_q ? lock1 : lock0;

  // Next-state and registered-output logic for the IDLE/ACCESS/ACK sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    grant_s     = 1'b0;
    win_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if (lock_q && own_req_s) begin
          grant_s = 1'b1;
          win_s   = owner_q;
        end else begin
          // An idle lock holder forfeits the lock so the other port cannot starve.
          lock_d = 1'b0;
          if (req0 && req1) begin
            grant_s = 1'b1;
            win_s   = ~last_q;
          end else if (req0) begin
            grant_s = 1'b1;
            win_s   = 1'b0;
          end else if (req1) begin
            grant_s = 1'b1;
            win_s   = 1'b1;
          end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
          end
        end

        if (grant_s) begin
          state_d     = ACCESS;
          owner_d     = win_s;
          cnt_d       = CNT_INIT;
          mem_addr_d  = win_s ? addr1 : addr0;
          mem_we_d    = win_s ? we1 : we0;
          mem_wdata_d = win_s ? wdata1 : wdata0;
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!mem_we_q) begin
            if (owner_q) begin
              rdata1_d = mem_rdata;
            end else begin
              rdata0_d = mem_rdata;
            end
          end else begin
            rdata0_d = rdata0_q;
            rdata1_d = rdata1_q;
          end
          mem_we_d = 1'b0;
          ack0_d   = ~owner_q;
          ack1_d   = owner_q;
          last_d   = owner_q;
          lock_d   = own_lock_s;
          state_d  = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      rdata0_q    <= {DW{1'b0}};
      rdata1_q    <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
// A schedule-based reference model predicts every output each cycle.
module tb_mem_arbiter2;

  typedef struct {
    bit       we;
    bit [7:0] addr;
    bit [7:0] wd;
    bit       lk;
  } rq_t;

  typedef struct {
    int d;
    int e;
    int p;
  } ak_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0 [2], we0 [2], lock0 [2], req1 [2], we1 [2], lock1 [2];
  logic [7:0] addr0 [2], wdata0 [2], addr1 [2], wdata1 [2];
  logic       ack0 [2], ack1 [2], mem_we [2], busy [2], owner [2];
  logic [7:0] rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [7:0] ram [2][256];

  assign mem_rdata[0] = ram[0][mem_addr[0]];
  assign mem_rdata[1] = ram[1][mem_addr[1]];

  mem_arbiter2 #(.AW(8), .DW(8), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .lock0(lock0[0]),
    .ack0(ack0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .lock1(lock1[0]),
    .ack1(ack1[0]), .rdata1(rdata1[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_arbiter2 #(.AW(8), .DW(8), .MEM_LAT(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .lock0(lock0[1]),
    .ack0(ack0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .lock1(lock1[1]),
    .ack1(ack1[1]), .rdata1(rdata1[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          edge_n = 0;
  int          base   = 0;
  int          busy_cnt [2];
  int          we_cnt [2];
  rq_t         rq [4][$];
  ak_t         alog [$];

  // Reference model: an access granted at edge g acks at edge g+L, and the
  // arbiter samples requests again at edge g+L+2.
  int       nxt [2], ack_e [2];
  bit       m_last [2], m_lock [2], m_own [2], m_we [2], cur_we [2];
  bit       m_ack0 [2], m_ack1 [2];
  bit [7:0] m_addr [2], m_wd [2], m_rd0 [2], m_rd1 [2];
  bit [7:0] mexp [2][256];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic rq_t mk(input bit we, input bit [7:0] a, input bit [7:0] d, input bit lk);
    rq_t r;
    r.we = we; r.addr = a; r.wd = d; r.lk = lk;
    return r;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d: got %0h want %0h (edge %0d)", tag, d, obs, exp, edge_n);
    end
  endtask

  task automatic model(input int i);
    bit g, w, r0, r1;
    int e;
    e = edge_n;
    if (rst) begin
      nxt[i] = e + 1; ack_e[i] = -100;
      m_last[i] = 1'b1; m_lock[i] = 1'b0; m_own[i] = 1'b0; m_we[i] = 1'b0;
      m_ack0[i] = 1'b0; m_ack1[i] = 1'b0;
      m_addr[i] = 8'h00; m_wd[i] = 8'h00; m_rd0[i] = 8'h00; m_rd1[i] = 8'h00;
      return;
    end
    m_ack0[i] = 1'b0;
    m_ack1[i] = 1'b0;
    if (e == ack_e[i]) begin
      if (m_own[i]) m_ack1[i] = 1'b1; else m_ack0[i] = 1'b1;
      if (!cur_we[i]) begin
        if (m_own[i]) m_rd1[i] = mexp[i][m_addr[i]]; else m_rd0[i] = mexp[i][m_addr[i]];
      end
      m_we[i]   = 1'b0;
      m_last[i] = m_own[i];
      m_lock[i] = m_own[i] ? lock1[i] : lock0[i];
    end
    if (e == nxt[i]) begin
      r0 = req0[i]; r1 = req1[i];
      g = 1'b1; w = 1'b0;
      if (m_lock[i] && (m_own[i] ? r1 : r0)) w = m_own[i];
      else begin
        m_lock[i] = 1'b0;
        if (r0 && r1) w = !m_last[i];
        else if (r0) w = 1'b0;
        else if (r1) w = 1'b1;
        else g = 1'b0;
      end
      if (g) begin
        m_own[i]  = w;
        m_addr[i] = w ? addr1[i] : addr0[i];
        m_wd[i]   = w ? wdata1[i] : wdata0[i];
        cur_we[i] = w ? we1[i] : we0[i];
        m_we[i]   = cur_we[i];
        if (cur_we[i]) mexp[i][m_addr[i]] = m_wd[i];
        ack_e[i] = e + lat(i);
        nxt[i]   = e + lat(i) + 2;
      end else begin
        nxt[i] = e + 1;
      end
    end
  endtask

  task automatic set_port(input int i, input int p, input bit r, input rq_t q);
    if (p == 0) begin
      req0[i] = r; we0[i] = q.we; addr0[i] = q.addr; wdata0[i] = q.wd; lock0[i] = q.lk;
    end else begin
      req1[i] = r; we1[i] = q.we; addr1[i] = q.addr; wdata1[i] = q.wd; lock1[i] = q.lk;
    end
  endtask

  // Masters hold a request until acked, then present the next queued one.
  task automatic drive_masters(input bit after_edge);
    int i, p;
    logic cur, ak;
    rq_t r;
    for (int k = 0; k < 4; k++) begin
      i = k / 2; p = k % 2;
      cur = p ? req1[i] : req0[i];
      ak  = p ? ack1[i] : ack0[i];
      if (cur !== 1'b1 || (after_edge && ak === 1'b1)) begin
        if (rq[k].size() > 0) begin
          r = rq[k].pop_front();
          set_port(i, p, 1'b1, r);
        end else begin
          set_port(i, p, 1'b0, mk(1'b0, 8'h00, 8'h00, 1'b0));
        end
      end
    end
  endtask

  task automatic step();
    bit       wr [2];
    bit [7:0] wa [2], wd [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      wr[i] = (mem_we[i] === 1'b1); wa[i] = mem_addr[i]; wd[i] = mem_wdata[i];
    end
    @(posedge clk);
    #1;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) ram[i][wa[i]] = wd[i];
      model(i);
      chk("ack0", i, ack0[i], m_ack0[i]);
      chk("ack1", i, ack1[i], m_ack1[i]);
      chk("rdata0", i, rdata0[i], m_rd0[i]);
      chk("rdata1", i, rdata1[i], m_rd1[i]);
      chk("mem_addr", i, mem_addr[i], m_addr[i]);
      chk("mem_we", i, mem_we[i], m_we[i]);
      chk("mem_wdata", i, mem_wdata[i], m_wd[i]);
      chk("owner", i, owner[i], m_own[i]);
      chk("busy", i, busy[i], (nxt[i] != edge_n + 1));
      if (ack0[i] === 1'b1) alog.push_back('{d: i, e: edge_n - base, p: 0});
      if (ack1[i] === 1'b1) alog.push_back('{d: i, e: edge_n - base, p: 1});
      if (busy[i] === 1'b1) busy_cnt[i]++;
      if (mem_we[i] === 1'b1) we_cnt[i]++;
    end
    drive_masters(1'b1);
  endtask

  task automatic start_test();
    alog.delete();
    base = edge_n;
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; we_cnt[i] = 0;
    end
    drive_masters(1'b0);
  endtask

  task automatic chk_ack(input string tag, input int n, input int d, input int p, input int e);
    if (n < alog.size()) begin
      chk({tag, "_dut"}, d, alog[n].d, d);
      chk({tag, "_port"}, d, alog[n].p, p);
      chk({tag, "_cycle"}, d, alog[n].e, e);
    end else begin
      chk({tag, "_missing"}, d, alog.size(), n + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_port(k / 2, k % 2, 1'b0, mk(1'b0, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) begin
        ram[i][a]  = 8'($urandom);
        mexp[i][a] = ram[i][a];
      end
    repeat (2) step();
    rst = 1'b0;

    // 1: single read on the MEM_LAT=1 instance
    ram[0][8'h10] = 8'hAB; mexp[0][8'h10] = 8'hAB;
    rq[0].push_back(mk(1'b0, 8'h10, 8'h00, 1'b0));
    start_test();
    repeat (6) step();
    chk("t1_acks", 0, alog.size(), 1);
    chk_ack("t1", 0, 0, 0, 2);
    chk("t1_rdata0", 0, rdata0[0], 8'hAB);
    chk("t1_busy_cycles", 0, busy_cnt[0], 2);

    // 2: simultaneous requests right after reset
    rst = 1'b1; step(); rst = 1'b0;
    rq[0].push_back(mk(1'b0, 8'h20, 8'h00, 1'b0));
    rq[1].push_back(mk(1'b1, 8'h21, 8'h5C, 1'b0));
    start_test();
    repeat (8) step();
    chk("t2_acks", 0, alog.size(), 2);
    chk_ack("t2a", 0, 0, 0, 2);
    chk_ack("t2b", 1, 0, 1, 5);
    chk("t2_mem21", 0, ram[0][8'h21], 8'h5C);

    // 3: continuous contention alternates every MEM_LAT+2 cycles
    for (int n = 0; n < 3; n++) begin
      rq[0].push_back(mk(1'b0, 8'($urandom), 8'h00, 1'b0));
      rq[1].push_back(mk(1'b0, 8'($urandom), 8'h00, 1'b0));
    end
    start_test();
    repeat (22) step();
    chk("t3_acks", 0, alog.size(), 6);
    for (int n = 0; n < 6; n++) chk_ack("t3", n, 0, n % 2, 2 + 3 * n);

    // 4: locked burst from port 1 while port 0 waits
    rq[1].push_back(mk(1'b1, 8'hF0, 8'h01, 1'b1));
    rq[1].push_back(mk(1'b1, 8'hF1, 8'h02, 1'b1));
    rq[1].push_back(mk(1'b1, 8'hF2, 8'h03, 1'b0));
    start_test();
    step();
    rq[0].push_back(mk(1'b0, 8'hF0, 8'h00, 1'b0));
    drive_masters(1'b0);
    repeat (16) step();
    chk("t4_acks", 0, alog.size(), 4);
    chk_ack("t4a", 0, 0, 1, 2);
    chk_ack("t4b", 1, 0, 1, 5);
    chk_ack("t4c", 2, 0, 1, 8);
    chk_ack("t4d", 3, 0, 0, 11);
    chk("t4_memF0", 0, ram[0][8'hF0], 8'h01);
    chk("t4_memF1", 0, ram[0][8'hF1], 8'h02);
    chk("t4_memF2", 0, ram[0][8'hF2], 8'h03);
    chk("t4_rdata0", 0, rdata0[0], 8'h01);

    // 5: write on the MEM_LAT=3 instance
    rq[3].push_back(mk(1'b1, 8'h40, 8'h99, 1'b0));
    start_test();
    repeat (8) step();
    chk("t5_acks", 1, alog.size(), 1);
    chk_ack("t5", 0, 1, 1, 4);
    chk("t5_we_cycles", 1, we_cnt[1], 3);
    chk("t5_mem40", 1, ram[1][8'h40], 8'h99);

    // 6: reset in the middle of a MEM_LAT=3 read; request stays held
    ram[1][8'h55] = 8'h3C; mexp[1][8'h55] = 8'h3C;
    rq[2].push_back(mk(1'b0, 8'h55, 8'h00, 1'b0));
    start_test();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_busy_after_rst", 1, busy[1], 1'b0);
    chk("t6_addr_after_rst", 1, mem_addr[1], 8'h00);
    chk("t6_rdata_after_rst", 1, rdata0[1], 8'h00);
    repeat (8) step();
    chk("t6_acks", 1, alog.size(), 1);
    chk_ack("t6", 0, 1, 0, 6);
    chk("t6_rdata0", 1, rdata0[1], 8'h3C);

    // Random traffic on both instances with occasional resets
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (rq[k].size() == 0 && $urandom_range(0, 2) == 0)
          rq[k].push_back(mk(1'($urandom), 8'h80 + 8'($urandom_range(0, 15)),
                             8'($urandom), ($urandom_range(0, 3) == 0)));
      end
      rst = ($urandom_range(0, 149) == 0);
      drive_masters(1'b0);
      step();
    end
    rst = 1'b0;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
